// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - loads a host byte stream into word memory, then releases the cpu to run it
// Owns the single memory port: loader writes while loading, cpu passes through while running.
module mem_loader #(
    parameter int ADDR_W    = 14,
    parameter int LEN_W     = 16,
    parameter int BASE_ADDR = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [LEN_W-1:0]  i_length,
    input  logic              i_data_valid,
    input  logic [7:0]        i_data,
    output logic              o_data_ready,
    output logic              o_cpu_rst,
    output logic              o_cpu_enable,
    input  logic              i_cpu_mem_write_en,
    input  logic [ADDR_W-1:0] i_cpu_mem_addr,
    input  logic [31:0]       i_cpu_mem_data,
    input  logic              i_cpu_halted,
    output logic              o_mem_write_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_data,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [1:0]         lane_q, lane_d;
    logic [31:0]        buf_q, buf_d;
    logic               ld_we_q, ld_we_d;
    logic [ADDR_W-1:0]  ld_addr_q, ld_addr_d;
    logic [31:0]        ld_data_q, ld_data_d;
    logic               data_ready_q, cpu_rst_q, cpu_enable_q, busy_q, done_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        lane_d    = lane_q;
        buf_d     = buf_q;
        ld_we_d   = 1'b0;
        ld_addr_d = '0;
        ld_data_d = '0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    addr_d  = ADDR_W'(BASE_ADDR);
                    rem_d   = i_length;
                    lane_d  = 2'd0;
                    buf_d   = '0;
                    state_d = (i_length != '0) ? S_RECV : S_RUN;
                end
            end
            S_RECV: begin
                if (i_data_valid) begin
                    buf_d[{lane_q, 3'b000} +: 8] = i_data;
                    rem_d  = rem_q - LEN_W'(1);
                    lane_d = lane_q + 2'd1;
                    // The write registers are loaded here so they line up with the WRITE state.
                    if (lane_q == 2'd3 || rem_q == LEN_W'(1)) begin
                        state_d   = S_WRITE;
                        ld_we_d   = 1'b1;
                        ld_addr_d = addr_q;
                        ld_data_d = buf_d;
                    end
                end
            end
            S_WRITE: begin
                addr_d  = addr_q + ADDR_W'(4);
                buf_d   = '0;
                lane_d  = 2'd0;
                state_d = (rem_q == '0) ? S_RUN : S_RECV;
            end
            S_RUN: begin
                if (i_cpu_halted) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            rem_q        <= '0;
            lane_q       <= '0;
            buf_q        <= '0;
            ld_we_q      <= 1'b0;
            ld_addr_q    <= '0;
            ld_data_q    <= '0;
            data_ready_q <= 1'b0;
            cpu_rst_q    <= 1'b1;
            cpu_enable_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            lane_q       <= lane_d;
            buf_q        <= buf_d;
            ld_we_q      <= ld_we_d;
            ld_addr_q    <= ld_addr_d;
            ld_data_q    <= ld_data_d;
            data_ready_q <= (state_d == S_RECV);
            cpu_rst_q    <= (state_d != S_RUN);
            cpu_enable_q <= (state_d == S_RUN);
            busy_q       <= (state_d == S_RECV) || (state_d == S_WRITE);
            done_q       <= (state_d == S_DONE);
        end
    end

    // cpu outputs are already registered, so the pass-through mux adds no read latency.
    assign o_mem_write_en = cpu_enable_q ? i_cpu_mem_write_en : ld_we_q;
    assign o_mem_addr     = cpu_enable_q ? i_cpu_mem_addr     : ld_addr_q;
    assign o_mem_data     = cpu_enable_q ? i_cpu_mem_data     : ld_data_q;

    assign o_data_ready = data_ready_q;
    assign o_cpu_rst    = cpu_rst_q;
    assign o_cpu_enable = cpu_enable_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;

endmodule
